// File: rtl/cipher_pkg.sv
// Shared types and helpers for the Caesar cipher engine.
package cipher_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SHIFT = 2'd1,
    OUT   = 2'd2
  } state_e;

  localparam int DEF_ALPHA = 26;
  localparam int DEF_SYM_W = 5;

  // Pointer width for an n-entry range; never narrower than one bit.
  function automatic int ptr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cipher_mod_shift.sv
// Combinational modular add/subtract of one symbol, with illegal-symbol flag.
// Optional subtract path: CIPHER_DECRYPT_EN.
module cipher_mod_shift
  import cipher_pkg::*;
#(
  parameter int ALPHA = DEF_ALPHA,
  parameter int SYM_W = DEF_SYM_W
) (
  input  logic [SYM_W-1:0] sym,
  input  logic [SYM_W-1:0] shift,
  input  logic             dec,
  output logic [SYM_W-1:0] res,
  output logic             illegal
);

  localparam logic [SYM_W:0] ALPHA_X = (SYM_W+1)'(ALPHA);

  logic [SYM_W:0] sum;

`ifndef CIPHER_DECRYPT_EN
  logic unused_dec;
  assign unused_dec = dec;
`endif

  // One extra bit holds the carry (encrypt) or the borrow sign (decrypt).
  always_comb begin
    illegal = ({1'b0, sym} >= ALPHA_X);
    sum     = {1'b0, sym} + {1'b0, shift};
    if (sum >= ALPHA_X) sum = sum - ALPHA_X;
`ifdef CIPHER_DECRYPT_EN
    if (dec) begin
      sum = {1'b0, sym} - {1'b0, shift};
      if (sum[SYM_W]) sum = sum + ALPHA_X;
    end
`endif
    res = illegal ? sym : sum[SYM_W-1:0];
  end

endmodule

// File: rtl/caesar_cipher_engine.sv
// Buffered Caesar cipher: LOAD a message, SHIFT it in place, stream it OUT.
// Decrypt support is compiled in only with CIPHER_DECRYPT_EN.
module caesar_cipher_engine
  import cipher_pkg::*;
#(
  parameter int MSG_LEN = 6,
  parameter int ALPHA   = DEF_ALPHA,
  parameter int SYM_W   = DEF_SYM_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SYM_W-1:0] in_sym,
  input  logic             in_last,
  input  logic [SYM_W-1:0] shift,
  input  logic             decrypt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SYM_W-1:0] out_sym,
  output logic             out_last,
  output logic             busy,
  output logic             err
);

  localparam int PTR_W = ptr_w(MSG_LEN);
  localparam int CNT_W = ptr_w(MSG_LEN + 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MSG_LEN - 1);
  localparam logic [SYM_W:0]   ALPHA_X  = (SYM_W+1)'(ALPHA);

  state_e state_q, state_d;

  logic [SYM_W-1:0] sym_buf [MSG_LEN];
  logic [CNT_W-1:0] wr_ptr, sh_ptr, rd_ptr, len_r, len_m1;
  logic [SYM_W-1:0] shift_r, sh_res;
  logic [SYM_W:0]   shift_red;
  logic             sh_illegal, acc, first_acc, end_load, out_hs;

  assign acc       = (state_q == LOAD) && in_valid;
  assign first_acc = acc && (wr_ptr == '0);
  assign end_load  = acc && (in_last || (wr_ptr == LAST_IDX));
  assign len_m1    = len_r - ONE;
  assign out_hs    = (state_q == OUT) && out_ready;
  // Single conditional subtraction; shifts of 2*ALPHA or more are not folded.
  assign shift_red = ({1'b0, shift} >= ALPHA_X) ? {1'b0, shift} - ALPHA_X
                                                : {1'b0, shift};

`ifdef CIPHER_DECRYPT_EN
  logic dec_r;
  // Direction is latched with the first symbol, like the shift amount.
  always_ff @(posedge clk) begin
    if (!resetn)        dec_r <= 1'b0;
    else if (first_acc) dec_r <= decrypt;
  end
`else
  logic dec_r, unused_decrypt;
  assign dec_r          = 1'b0;
  assign unused_decrypt = decrypt;
`endif

  cipher_mod_shift #(.ALPHA(ALPHA), .SYM_W(SYM_W)) u_mod_shift (
    .sym     (sym_buf[sh_ptr[PTR_W-1:0]]),
    .shift   (shift_r),
    .dec     (dec_r),
    .res     (sh_res),
    .illegal (sh_illegal)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= LOAD;
    else         state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (end_load) state_d = SHIFT;
      SHIFT:   if (sh_ptr == len_m1) state_d = OUT;
      OUT:     if (out_hs && out_last) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Buffer, pointers and per-message configuration.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < MSG_LEN; i++) sym_buf[i] <= '0;
      wr_ptr  <= '0;
      sh_ptr  <= '0;
      rd_ptr  <= '0;
      len_r   <= '0;
      shift_r <= '0;
      err     <= 1'b0;
    end else begin
      case (state_q)
        LOAD: if (acc) begin
          sym_buf[wr_ptr[PTR_W-1:0]] <= in_sym;
          wr_ptr <= wr_ptr + ONE;
          if (first_acc) begin
            shift_r <= shift_red[SYM_W-1:0];
            err     <= 1'b0;
          end
          if (end_load) len_r <= wr_ptr + ONE;
        end
        SHIFT: begin
          sym_buf[sh_ptr[PTR_W-1:0]] <= sh_res;
          if (sh_illegal) err <= 1'b1;
          sh_ptr <= (sh_ptr == len_m1) ? '0 : sh_ptr + ONE;
        end
        OUT: if (out_ready) begin
          if (out_last) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            sh_ptr <= '0;
          end else begin
            rd_ptr <= rd_ptr + ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    in_ready  = (state_q == LOAD);
    busy      = (state_q != LOAD);
    out_valid = (state_q == OUT);
    out_sym   = out_valid ? sym_buf[rd_ptr[PTR_W-1:0]] : '0;
    out_last  = out_valid && (rd_ptr == len_m1);
  end

endmodule

// File: tb/tb_caesar_cipher_engine.sv
// Directed bench for caesar_cipher_engine, hand-computed expectations.
module tb_caesar_cipher_engine;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       in_valid = 1'b0, in_last = 1'b0, decrypt = 1'b0;
  logic [4:0] in_sym = '0, shift = '0;
  logic       out_ready = 1'b1;
  logic       in_ready, out_valid, out_last, busy, err;
  logic [4:0] out_sym;

  int n_chk = 0;
  int n_bad = 0;
  int sv[8];
  int ev[8];
  int lat;
  int err_first;

  always #5 clk = ~clk;

  caesar_cipher_engine #(.MSG_LEN(6), .ALPHA(26), .SYM_W(5)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym), .in_last(in_last),
    .shift(shift), .decrypt(decrypt),
    .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym), .out_last(out_last),
    .busy(busy), .err(err)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive n symbols from sv[], one per cycle; returns #1 after the final accept.
  task automatic send(input int n, input int sh, input bit dec, input bit use_last);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_sym   = 5'(sv[i]);
      in_last  = use_last && (i == n - 1);
      shift    = 5'(sh);
      decrypt  = dec;
      chk("in_ready_load", int'(in_ready), 1);
      tick();
      if (i == 0) err_first = int'(err);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Cycles from the final accept cycle to the first out_valid cycle.
  task automatic measure_lat(output int l);
    l = 1;
    while (!out_valid && l < 100) begin
      tick();
      l++;
    end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
  endtask

  // Consume n symbols against ev[]; optionally stall 5 cycles before symbol stall_at.
  task automatic recv(input int n, input int stall_at);
    logic [4:0] held;
    for (int i = 0; i < n; i++) begin
      for (int t = 0; t < 100 && !out_valid; t++) tick();
      chk("out_valid", int'(out_valid), 1);
      if (i == stall_at) begin
        out_ready = 1'b0;
        held = out_sym;
        repeat (5) begin
          tick();
          chk("stall_sym", int'(out_sym), int'(held));
          chk("stall_valid", int'(out_valid), 1);
          chk("stall_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
      end
      chk($sformatf("out_sym[%0d]", i), int'(out_sym), ev[i]);
      chk($sformatf("out_last[%0d]", i), int'(out_last), (i == n - 1) ? 1 : 0);
      tick();
    end
    chk("in_ready_after", int'(in_ready), 1);
    chk("out_valid_after", int'(out_valid), 0);
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    resetn = 1'b1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sym", int'(out_sym), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);

    // Full message, forced end, shift 3: HELLOZ
    sv = '{7, 4, 11, 11, 14, 25, 0, 0};
    ev = '{10, 7, 14, 14, 17, 2, 0, 0};
    send(6, 3, 1'b0, 1'b0);
    chk("hello_busy", int'(busy), 1);
    chk("hello_in_ready", int'(in_ready), 0);
    measure_lat(lat);
    chk("hello_lat", lat, 7);
    recv(6, -1);

    // Short message with decrypt request
    sv = '{0, 1, 2, 0, 0, 0, 0, 0};
`ifdef CIPHER_DECRYPT_EN
    ev = '{23, 24, 25, 0, 0, 0, 0, 0};
`else
    ev = '{3, 4, 5, 0, 0, 0, 0, 0};
`endif
    send(3, 3, 1'b1, 1'b1);
    measure_lat(lat);
    chk("dec_lat", lat, 4);
    recv(3, -1);

    // Out-of-range shift and illegal symbol
    sv = '{30, 5, 0, 0, 0, 0, 0, 0};
    ev = '{30, 8, 0, 0, 0, 0, 0, 0};
    send(2, 29, 1'b0, 1'b1);
    measure_lat(lat);
    chk("ill_err", int'(err), 1);
    recv(2, -1);
    chk("ill_err_sticky", int'(err), 1);

    // Backpressure mid-stream; first accept also clears err
    sv = '{0, 1, 2, 3, 4, 0, 0, 0};
    ev = '{1, 2, 3, 4, 5, 0, 0, 0};
    send(5, 1, 1'b0, 1'b1);
    chk("err_clear_first", err_first, 0);
    measure_lat(lat);
    chk("bp_lat", lat, 6);
    recv(5, 2);

    // Reset during SHIFT with 4 symbols loaded
    sv = '{31, 1, 2, 3, 0, 0, 0, 0};
    send(4, 2, 1'b0, 1'b1);
    tick();
    chk("mid_err_set", int'(err), 1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("mid_in_ready", int'(in_ready), 1);
    chk("mid_out_valid", int'(out_valid), 0);
    chk("mid_err", int'(err), 0);
    chk("mid_busy", int'(busy), 0);
    sv = '{1, 0, 0, 0, 0, 0, 0, 0};
    ev = '{2, 0, 0, 0, 0, 0, 0, 0};
    send(1, 1, 1'b0, 1'b1);
    measure_lat(lat);
    chk("mid_next_lat", lat, 2);
    recv(1, -1);

    // Single symbol wrap: 25 + 1 -> 0
    sv = '{25, 0, 0, 0, 0, 0, 0, 0};
    ev = '{0, 0, 0, 0, 0, 0, 0, 0};
    send(1, 1, 1'b0, 1'b1);
    measure_lat(lat);
    chk("single_lat", lat, 2);
    recv(1, -1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
